// File: rtl/uart_rx_word_if.sv
// Byte-in / word-out bundle for uart_rx_word; the data width follows BYTES_PER_WORD.
// o_byte_cnt widens to 4 bits when UART_RX_WORD_CHECKSUM_EN is defined.
interface uart_rx_word_if #(
    parameter int BYTES_PER_WORD = 2
);
    localparam int W = 8 * BYTES_PER_WORD;
`ifdef UART_RX_WORD_CHECKSUM_EN
    localparam int CW = 4;
`else
    localparam int CW = 3;
`endif

    // Input side: i_rxdatval qualifies i_rxbyte for exactly one cycle, and there is no back-pressure.
    // Output side: o_word is taken on any cycle where o_wordvalid & i_wordready are both high.
    // o_word and o_wordvalid are held until that cycle.
    logic [7:0]    i_rxbyte;
    logic          i_rxdatval;
    logic [W-1:0]  o_word;
    logic          o_wordvalid;
    logic          i_wordready;
    logic          o_overrun;
    logic          o_timeout;
    logic          o_csum_err;
    logic [CW-1:0] o_byte_cnt;
    logic [1:0]    dbg_state;

    modport slave (
        input  i_rxbyte, i_rxdatval, i_wordready,
        output o_word, o_wordvalid, o_overrun, o_timeout, o_csum_err, o_byte_cnt, dbg_state
    );

    modport master (
        output i_rxbyte, i_rxdatval, i_wordready,
        input  o_word, o_wordvalid, o_overrun, o_timeout, o_csum_err, o_byte_cnt, dbg_state
    );
endinterface

// File: rtl/uart_rx_word.sv
// Packs BYTES_PER_WORD UART bytes into one word with an idle-timeout and a valid/ready output register.
// Optional trailing XOR check byte: define UART_RX_WORD_CHECKSUM_EN.
module uart_rx_word #(
    parameter int BYTES_PER_WORD = 2,
    parameter bit MSB_FIRST      = 1'b1,
    parameter int TIMEOUT_CLKS   = 12500
) (
    input logic           i_clk,
    input logic           i_rst,
    uart_rx_word_if.slave bus
);
    localparam int W = 8 * BYTES_PER_WORD;
`ifdef UART_RX_WORD_CHECKSUM_EN
    localparam int CW = 4;
`else
    localparam int CW = 3;
`endif
    localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam bit TO_EN = (TIMEOUT_CLKS != 0);
    localparam logic [TW-1:0] T_LAST   = TW'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);
    localparam logic [CW-1:0] LAST_IDX = CW'(BYTES_PER_WORD - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ASSEMBLE = 2'd1;
    localparam logic [1:0] ST_CSUM     = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  shreg;
    logic [W-1:0]  placed;
    logic [TW-1:0] tcnt;
    logic [W-1:0]  word_q;
    logic          valid_q;
    logic          overrun_q;
    logic          timeout_q;
    logic          csum_err_q;
    logic          timer_active;
    logic          expire;
    logic          complete;
    logic [W-1:0]  word_new;
`ifdef UART_RX_WORD_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    // Shift buffer with the incoming byte dropped into slot cnt.
    always_comb begin
        placed = shreg;
        for (int k = 0; k < BYTES_PER_WORD; k++) begin
            if (cnt == CW'(k)) begin
                if (MSB_FIRST) placed[W-8-8*k +: 8] = bus.i_rxbyte;
                else           placed[8*k +: 8]     = bus.i_rxbyte;
            end
        end
    end

    assign timer_active = (state != ST_IDLE);
    assign expire       = TO_EN && timer_active && !bus.i_rxdatval && (tcnt == T_LAST);

`ifdef UART_RX_WORD_CHECKSUM_EN
    assign complete = bus.i_rxdatval && (state == ST_CSUM) && (bus.i_rxbyte == csum);
    assign word_new = shreg;
`else
    assign complete = bus.i_rxdatval && (state != ST_CSUM) && (cnt == LAST_IDX);
    assign word_new = placed;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            tcnt       <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            csum_err_q <= 1'b0;
`ifdef UART_RX_WORD_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            overrun_q  <= 1'b0;
            timeout_q  <= 1'b0;
            csum_err_q <= 1'b0;

            if (bus.i_rxdatval || !timer_active || expire) tcnt <= '0;
            else if (TO_EN)                                 tcnt <= tcnt + 1'b1;

            // A byte landing on the expiry cycle wins because expire requires no strobe.
            if (expire) begin
                state     <= ST_IDLE;
                cnt       <= '0;
                timeout_q <= 1'b1;
            end else if (bus.i_rxdatval) begin
                case (state)
                    ST_IDLE, ST_ASSEMBLE: begin
                        shreg <= placed;
`ifdef UART_RX_WORD_CHECKSUM_EN
                        csum  <= (cnt == '0) ? bus.i_rxbyte : (csum ^ bus.i_rxbyte);
`endif
                        if (cnt == LAST_IDX) begin
`ifdef UART_RX_WORD_CHECKSUM_EN
                            state <= ST_CSUM;
                            cnt   <= CW'(BYTES_PER_WORD);
`else
                            state <= ST_IDLE;
                            cnt   <= '0;
`endif
                        end else begin
                            state <= ST_ASSEMBLE;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                    ST_CSUM: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
`ifdef UART_RX_WORD_CHECKSUM_EN
                        if (bus.i_rxbyte != csum) csum_err_q <= 1'b1;
`endif
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end

            // A completion coinciding with a transfer reloads instead of overrunning.
            if (complete) begin
                if (!valid_q || bus.i_wordready) begin
                    word_q  <= word_new;
                    valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && bus.i_wordready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_word      = word_q;
    assign bus.o_wordvalid = valid_q;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_timeout   = timeout_q;
    assign bus.o_csum_err  = csum_err_q;
    assign bus.o_byte_cnt  = cnt;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_uart_rx_word.sv
// Directed bench for uart_rx_word: two instances (2-byte MSB-first with timeout, 4-byte LSB-first without).
// Words are checked by a queue-based monitor; pulses are counted and checked from the stimulus flow.
module tb_uart_rx_word;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef UART_RX_WORD_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    uart_rx_word_if #(.BYTES_PER_WORD(2)) bus_a ();
    uart_rx_word_if #(.BYTES_PER_WORD(4)) bus_b ();

    uart_rx_word #(.BYTES_PER_WORD(2), .MSB_FIRST(1'b1), .TIMEOUT_CLKS(100)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(bus_a)
    );
    uart_rx_word #(.BYTES_PER_WORD(4), .MSB_FIRST(1'b0), .TIMEOUT_CLKS(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(bus_b)
    );

    int checks = 0;
    int errors = 0;
    int to_a = 0, to_b = 0, ov_a = 0, ce_a = 0;
    logic [15:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on every accepted word, count status pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_a.o_wordvalid && bus_a.i_wordready) begin
                if (exp_q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mon_a: unexpected word %0h", bus_a.o_word);
                end else check("mon_a word", 64'(bus_a.o_word), 64'(exp_q_a.pop_front()));
            end
            if (bus_b.o_wordvalid && bus_b.i_wordready) begin
                if (exp_q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mon_b: unexpected word %0h", bus_b.o_word);
                end else check("mon_b word", 64'(bus_b.o_word), 64'(exp_q_b.pop_front()));
            end
            if (bus_a.o_timeout)  to_a++;
            if (bus_b.o_timeout)  to_b++;
            if (bus_a.o_overrun)  ov_a++;
            if (bus_a.o_csum_err) ce_a++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_a(input logic [7:0] b);
        bus_a.i_rxbyte = b; bus_a.i_rxdatval = 1'b1; cyc(1);
        bus_a.i_rxdatval = 1'b0; cyc(1);
    endtask

    task automatic send_b(input logic [7:0] b);
        bus_b.i_rxbyte = b; bus_b.i_rxdatval = 1'b1; cyc(1);
        bus_b.i_rxdatval = 1'b0; cyc(1);
    endtask

    // Send a 2-byte word to dut_a, appending the check byte when the feature is built in.
    task automatic word_a(input logic [7:0] b0, input logic [7:0] b1);
        send_a(b0); send_a(b1);
        if (CSUM_ON) send_a(b0 ^ b1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " a word"},    64'(bus_a.o_word), 64'h0);
        check({tag, " a valid"},   64'(bus_a.o_wordvalid), 64'h0);
        check({tag, " a cnt"},     64'(bus_a.o_byte_cnt), 64'h0);
        check({tag, " a overrun"}, 64'(bus_a.o_overrun), 64'h0);
        check({tag, " a timeout"}, 64'(bus_a.o_timeout), 64'h0);
        check({tag, " a csumerr"}, 64'(bus_a.o_csum_err), 64'h0);
        check({tag, " b word"},    64'(bus_b.o_word), 64'h0);
        check({tag, " b valid"},   64'(bus_b.o_wordvalid), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last;
        bus_a.i_rxbyte = '0; bus_a.i_rxdatval = 1'b0; bus_a.i_wordready = 1'b1;
        bus_b.i_rxbyte = '0; bus_b.i_rxdatval = 1'b0; bus_b.i_wordready = 1'b1;
        rst = 1'b1;
        cyc(3);
        check_reset("rst0");
        rst = 1'b0;
        cyc(2);

        // 0xAB,0xCD MSB-first: valid exactly one cycle, right after the final strobe.
        exp_q_a.push_back(16'hABCD);
        send_a(8'hAB);
        if (CSUM_ON) begin send_a(8'hCD); last = 8'h66; end
        else last = 8'hCD;
        bus_a.i_rxbyte = last; bus_a.i_rxdatval = 1'b1; cyc(1);
        bus_a.i_rxdatval = 1'b0;
        check("t1 valid rise", 64'(bus_a.o_wordvalid), 64'h1);
        check("t1 word", 64'(bus_a.o_word), 64'hABCD);
        cyc(1);
        check("t1 valid one cycle", 64'(bus_a.o_wordvalid), 64'h0);
        cyc(2);

        // 4-byte LSB-first with byte count stepping.
        exp_q_b.push_back(32'h44332211);
        send_b(8'h11); check("t2 cnt1", 64'(bus_b.o_byte_cnt), 64'd1);
        send_b(8'h22); check("t2 cnt2", 64'(bus_b.o_byte_cnt), 64'd2);
        send_b(8'h33); check("t2 cnt3", 64'(bus_b.o_byte_cnt), 64'd3);
        send_b(8'h44); check("t2 cnt4", 64'(bus_b.o_byte_cnt), CSUM_ON ? 64'd4 : 64'd0);
        if (CSUM_ON) send_b(8'h44);
        check("t2 cnt end", 64'(bus_b.o_byte_cnt), 64'd0);

        // TIMEOUT_CLKS=0: a long gap leaves the partial word in place.
        exp_q_b.push_back(32'hDDCCBBAA);
        send_b(8'hAA);
        cyc(300);
        check("t2 no timeout cnt", 64'(bus_b.o_byte_cnt), 64'd1);
        send_b(8'hBB); send_b(8'hCC); send_b(8'hDD);
        if (CSUM_ON) send_b(8'h00);
        cyc(2);
        check("t2 no timeout pulse", 64'(to_b), 64'd0);

        // Timeout: strobe at edge E0 expires at edge E100.
        send_a(8'h55);
        cyc(99);
        check("t3 timeout pulse", 64'(bus_a.o_timeout), 64'h1);
        check("t3 cnt cleared", 64'(bus_a.o_byte_cnt), 64'h0);
        exp_q_a.push_back(16'h6677);
        word_a(8'h66, 8'h77);
        cyc(2);
        check("t3 timeout count", 64'(to_a), 64'd1);

        // Byte on the expiry edge wins.
        exp_q_a.push_back(16'h5566);
        send_a(8'h55);
        cyc(98);
        send_a(8'h66);
        if (CSUM_ON) send_a(8'h33);
        cyc(2);
        check("t3 expiry edge no timeout", 64'(to_a), 64'd1);

        // Overrun: held word survives, second word dropped.
        bus_a.i_wordready = 1'b0;
        exp_q_a.push_back(16'h0102);
        word_a(8'h01, 8'h02);
        cyc(1);
        word_a(8'h03, 8'h04);
        cyc(2);
        check("t4 overrun count", 64'(ov_a), 64'd1);
        check("t4 held word", 64'(bus_a.o_word), 64'h0102);
        check("t4 held valid", 64'(bus_a.o_wordvalid), 64'h1);
        bus_a.i_wordready = 1'b1;
        cyc(3);
        check("t4 valid drops", 64'(bus_a.o_wordvalid), 64'h0);

        // Completion on the transfer cycle reloads without overrun.
        bus_a.i_wordready = 1'b0;
        exp_q_a.push_back(16'h1357);
        word_a(8'h13, 8'h57);
        cyc(2);
        exp_q_a.push_back(16'h2468);
        send_a(8'h24);
        if (CSUM_ON) begin send_a(8'h68); last = 8'h4C; end
        else last = 8'h68;
        bus_a.i_rxbyte = last; bus_a.i_rxdatval = 1'b1; bus_a.i_wordready = 1'b1; cyc(1);
        bus_a.i_rxdatval = 1'b0;
        check("t5 reload valid", 64'(bus_a.o_wordvalid), 64'h1);
        check("t5 reload word", 64'(bus_a.o_word), 64'h2468);
        cyc(2);
        check("t5 valid drops", 64'(bus_a.o_wordvalid), 64'h0);
        check("t5 no overrun", 64'(ov_a), 64'd1);

        // Reset mid-word discards the partial byte.
        send_a(8'h99);
        rst = 1'b1;
        cyc(2);
        check_reset("rst1");
        rst = 1'b0;
        cyc(1);
        exp_q_a.push_back(16'hBEEF);
        word_a(8'hBE, 8'hEF);
        cyc(2);

`ifdef UART_RX_WORD_CHECKSUM_EN
        exp_q_a.push_back(16'h1234);
        send_a(8'h12); send_a(8'h34); send_a(8'h26);
        cyc(2);
        send_a(8'h12); send_a(8'h34); send_a(8'h00);
        cyc(2);
        check("t6 csum err count", 64'(ce_a), 64'd1);
        check("t6 csum no word", 64'(bus_a.o_wordvalid), 64'h0);
`else
        check("t6 csum err tied", 64'(ce_a), 64'd0);
`endif

        cyc(5);
        check("final queue a", 64'(exp_q_a.size()), 64'd0);
        check("final queue b", 64'(exp_q_b.size()), 64'd0);
        check("final timeout a", 64'(to_a), 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
Parametrised word assembler that sits directly after the UART byte receiver. It packs a configurable number of received bytes into one word with a selectable byte order. Partial words are discarded after an inter-byte timeout. Completed words are presented on a valid/ready output register with overrun reporting. It feeds FIR coefficient/sample loading paths of any width that is a multiple of 8.

Parameters:
BYTES_PER_WORD, 2, bytes packed per word; legal range 1..8; W = 8*BYTES_PER_WORD
MSB_FIRST, 1, 1: first received byte lands in o_word[W-1:W-8]; 0: first byte lands in o_word[7:0]
TIMEOUT_CLKS, 12500, idle clocks between bytes before a partial word is discarded; 0 disables timeout

Ports:
i_clk  input  1  system clock; single clock domain
i_rst  input  1  synchronous, active-high reset
i_rxbyte  input  8  received byte, qualified by i_rxdatval
i_rxdatval  input  1  single-cycle strobe, one per received byte
o_word  output  W  assembled word, stable while o_wordvalid=1
o_wordvalid  output  1  output word valid
i_wordready  input  1  consumer accepts o_word when o_wordvalid & i_wordready
o_overrun  output  1  1-cycle pulse: completed word dropped because output register full
o_timeout  output  1  1-cycle pulse: partial word discarded by timeout
o_csum_err  output  1  1-cycle pulse: checksum mismatch (tied 0 when feature compiled out)
o_byte_cnt  output  3  bytes currently held in the partial word (0..BYTES_PER_WORD-1)

Behaviour:
- Reset values: o_word=0, o_wordvalid=0, o_overrun=0, o_timeout=0, o_csum_err=0, o_byte_cnt=0. The shift buffer and timeout counter are cleared. Reset mid-word discards the partial word.
- States:
  - IDLE (cnt=0).
  - ASSEMBLE (0<cnt<BYTES_PER_WORD).
  - CSUM (feature only; awaiting check byte).
- IDLE -> ASSEMBLE on the first byte. ASSEMBLE -> IDLE on the final byte, or on timeout.
- Byte placement: the byte at index k (0 = first) goes to bits [W-1-8k : W-8-8k] if MSB_FIRST=1, else to bits [8k+7 : 8k].
- Completion latency: o_wordvalid rises the cycle after the i_rxdatval of the final byte. o_word updates in the same cycle.
- Output handshake:
  - The transfer occurs on a cycle with o_wordvalid & i_wordready. o_wordvalid falls the next cycle unless a new word completes in that same cycle.
  - Completion while o_wordvalid=1 and i_wordready=0: the new word is dropped, the held word is unchanged, and o_overrun pulses one cycle after the final byte. The assembler returns to IDLE.
  - Completion in the same cycle as the transfer: the new word loads and o_wordvalid stays 1. No overrun.
- Timeout: the counter clears on every i_rxdatval and counts only while cnt>0 (or in CSUM).
  - When the counter reaches TIMEOUT_CLKS-1 with no byte, the partial word is discarded, cnt=0, and o_timeout pulses for 1 cycle.
  - A byte arriving in the same cycle as expiry wins: the byte is accepted and no timeout occurs.
  - TIMEOUT_CLKS=0: counter inactive, o_timeout never asserts.
- BYTES_PER_WORD=1: every byte completes a word, so o_byte_cnt stays 0 and timeout never fires.
- i_rxdatval strobes are at least 2 cycles apart (guaranteed by the UART byte rate). Back-to-back strobes are still handled correctly.
- No combinational path from any input to any output.

Optional Feature:
UART_RX_WORD_CHECKSUM_EN
- Defined:
  - After BYTES_PER_WORD data bytes, the FSM enters CSUM and expects one extra byte equal to the XOR of all data bytes.
  - Match: the word is published as normal, one cycle after the check byte. Overrun rules apply at that point.
  - Mismatch: the word is discarded, o_csum_err pulses for 1 cycle, and the FSM returns to IDLE.
  - Timeout also applies in CSUM.
  - o_byte_cnt reads BYTES_PER_WORD while in CSUM, so the port widens to 4 bits when defined.
- Undefined: no CSUM state, o_csum_err tied 0, o_byte_cnt is 3 bits.

Test Plan:
- BYTES_PER_WORD=2, MSB_FIRST=1, i_wordready=1. Send 0xAB then 0xCD -> o_word=0xABCD, o_wordvalid high exactly 1 cycle, starting the cycle after the second strobe.
- BYTES_PER_WORD=4, MSB_FIRST=0. Send 0x11,0x22,0x33,0x44 -> o_word=0x44332211. o_byte_cnt steps 1,2,3,0.
- BYTES_PER_WORD=2, TIMEOUT_CLKS=100. Send 0x55, wait 100 clocks, then send 0x66,0x77 -> o_timeout pulses once, o_word=0x6677, 0x55 never appears. Repeat with a byte arriving on the expiry cycle -> no timeout, byte accepted.
- BYTES_PER_WORD=2, i_wordready=0. Send 0x0102 then 0x0304 -> o_word holds 0x0102, o_overrun pulses once. Raise i_wordready -> one transfer of 0x0102, then o_wordvalid=0.
- Assert i_rst after the first byte of a 2-byte word, then send 0xBE,0xEF -> all outputs 0 during reset, next word is 0xBEEF.
- With UART_RX_WORD_CHECKSUM_EN, BYTES_PER_WORD=2:
  - Send 0x12,0x34,0x26 -> o_word=0x1234.
  - Send 0x12,0x34,0x00 -> o_csum_err pulses, o_wordvalid stays 0.
